// File: rtl/expr_seq_pkg.sv
// Shared widths, FSM encodings and the LFSR/MISR helpers for the expression-datapath
// vector sequencer.
package expr_seq_pkg;

   localparam int unsigned OPND_W = 60;
   localparam int unsigned Y_W    = 90;
   localparam int unsigned SIG_W  = 32;
   localparam int unsigned LFSR_W = 64;

   typedef logic [1:0] state_t;

   localparam state_t StIdle    = 2'd0;
   localparam state_t StDrive   = 2'd1;
   localparam state_t StSettle  = 2'd2;
   localparam state_t StCapture = 2'd3;

   // Fibonacci taps 64,63,61,60 -> bit positions 63,62,60,59.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
   localparam logic [SIG_W-1:0]  MISR_POLY = 32'h0040_0007;

   function automatic logic [SIG_W-1:0] fold_y(input logic [Y_W-1:0] y);
      return y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
   endfunction

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/expr_vector_sequencer_if.sv
// Bundles the run-control handshake, operand/result buses and run status of the
// sequencer; the sequencer uses the slave view, the harness the master view.
interface expr_vector_sequencer_if;
   import expr_seq_pkg::*;

   logic              start;
   logic              abort;
   logic [OPND_W-1:0] opnd;
   logic [Y_W-1:0]    y_in;
   logic              busy;
   logic              done;
   logic [15:0]       vec_count;
   logic [SIG_W-1:0]  signature;

   modport master (
      output start, abort, y_in,
      input  opnd, busy, done, vec_count, signature
   );

   modport slave (
      input  start, abort, y_in,
      output opnd, busy, done, vec_count, signature
   );

endinterface

// File: rtl/expr_misr.sv
// 32-bit MISR that folds each 90-bit expression result into the running signature,
// with a synchronous clear for the start of a run.
module expr_misr
   import expr_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [Y_W-1:0]   y_i,
   output logic [SIG_W-1:0] sig_o
);

   logic [SIG_W-1:0] sig_q, sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr_i) begin
         sig_d = '0;
      end else if (en_i) begin
         sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? MISR_POLY : '0) ^ fold_y(y_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/expr_vector_sequencer.sv
// Drives LFSR operand vectors into the expression block, holds each for a settle time,
// and compacts every captured result into a MISR signature.
module expr_vector_sequencer
   import expr_seq_pkg::*;
#(
   parameter int unsigned       NUM_VECTORS   = 256,
   parameter int unsigned       SETTLE_CYCLES = 1,
   parameter logic [LFSR_W-1:0] SEED          = 64'h1
) (
   input logic                    clk,
   input logic                    rst_n,
   expr_vector_sequencer_if.slave bus
);

   localparam logic [15:0] NumVec     = NUM_VECTORS[15:0];
   localparam logic [3:0]  SettleInit = 4'(SETTLE_CYCLES - 1);

   state_t            state_q, state_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [OPND_W-1:0] opnd_q, opnd_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [15:0]       vec_count_q, vec_count_d;
   logic              done_q, done_d;
   logic              misr_clr, misr_en;
   logic [SIG_W-1:0]  sig;

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      opnd_d      = opnd_q;
      cnt_d       = cnt_q;
      vec_count_d = vec_count_q;
      done_d      = done_q;
      misr_clr    = 1'b0;
      misr_en     = 1'b0;

      // abort outranks everything outside IDLE, including the final capture
      if (state_q != StIdle && bus.abort) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start && !bus.abort) begin
                  state_d     = StDrive;
                  vec_count_d = '0;
                  done_d      = 1'b0;
                  lfsr_d      = SEED;
                  misr_clr    = 1'b1;
               end
            end
            StDrive: begin
               opnd_d  = lfsr_q[OPND_W-1:0];
               cnt_d   = SettleInit;
               state_d = StSettle;
            end
            StSettle: begin
               if (cnt_q == 4'd0) begin
                  state_d = StCapture;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            StCapture: begin
               misr_en     = 1'b1;
               vec_count_d = vec_count_q + 16'd1;
               lfsr_d      = lfsr_step(lfsr_q);
               if (vec_count_d == NumVec) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StDrive;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         lfsr_q      <= SEED;
         opnd_q      <= '0;
         cnt_q       <= '0;
         vec_count_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         opnd_q      <= opnd_d;
         cnt_q       <= cnt_d;
         vec_count_q <= vec_count_d;
         done_q      <= done_d;
      end
   end

   expr_misr u_misr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (misr_clr),
      .en_i  (misr_en),
      .y_i   (bus.y_in),
      .sig_o (sig)
   );

   assign bus.opnd      = opnd_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = done_q;
   assign bus.vec_count = vec_count_q;
   assign bus.signature = sig;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Directed bench for expr_vector_sequencer: a run-schedule model checked every cycle,
// plus hand-computed expectations for reset, operands, signatures, abort and contention.
module tb_expr_vector_sequencer;

   localparam int unsigned NV = 4;
   localparam int unsigned ST = 2;
   localparam int unsigned P  = 2 + ST;
   localparam logic [63:0] SD = 64'h1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   expr_vector_sequencer_if bus ();

   logic [89:0] y_const = '0;
   logic        y_mode  = 1'b0;
   assign bus.y_in = y_mode ? ({3{bus.opnd[29:0]}} ^ y_const) : y_const;

   expr_vector_sequencer #(
      .NUM_VECTORS   (NV),
      .SETTLE_CYCLES (ST),
      .SEED          (SD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   int cyc_now = 0;
   int s_edge = 0;

   task automatic chk(input string name, input logic [89:0] act, input logic [89:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: a run is a timeline of edges since the start edge; vector k is loaded at
   // edge k*P+1 and captured at edge (k+1)*P.
   bit          m_active = 1'b0;
   int          m_t      = 0;
   logic [59:0] m_opnd   = '0;
   logic [63:0] m_lfsr   = SD;
   logic [31:0] m_sig    = '0;
   logic [15:0] m_vc     = '0;
   bit          m_done   = 1'b0;

   function automatic logic [31:0] m_misr(input logic [31:0] s, input logic [89:0] y);
      logic [31:0] f;
      f = y[31:0] ^ y[63:32] ^ 32'(y[89:64]);
      return (s << 1) ^ (s[31] ? 32'h0040_0007 : 32'h0) ^ f;
   endfunction

   task automatic model_step();
      if (!rst_n) begin
         m_active = 1'b0; m_opnd = '0; m_lfsr = SD; m_sig = '0; m_vc = '0; m_done = 1'b0;
      end else if (!m_active) begin
         if (bus.start && !bus.abort) begin
            m_active = 1'b1; m_t = 0; m_vc = '0; m_sig = '0; m_done = 1'b0; m_lfsr = SD;
         end
      end else if (bus.abort) begin
         m_active = 1'b0;
      end else begin
         m_t++;
         if (m_t % P == 1) m_opnd = m_lfsr[59:0];
         if (m_t % P == 0) begin
            m_sig  = m_misr(m_sig, bus.y_in);
            m_vc   = m_vc + 16'd1;
            m_lfsr = {m_lfsr[62:0], m_lfsr[63] ^ m_lfsr[62] ^ m_lfsr[60] ^ m_lfsr[59]};
            if (m_vc == NV) begin
               m_active = 1'b0;
               m_done   = 1'b1;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc_now++;
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         chk("cyc_opnd", bus.opnd, m_opnd);
         chk("cyc_busy", bus.busy, m_active);
         chk("cyc_done", bus.done, m_done);
         chk("cyc_vec_count", bus.vec_count, m_vc);
         chk("cyc_signature", bus.signature, m_sig);
      end
   end

   task automatic start_run();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      s_edge = cyc_now;
   endtask

   task automatic wait_done();
      while (!bus.done && (cyc_now - s_edge) < 100) @(negedge clk);
   endtask

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      rst_n     = 1'b0;
      ticks(3);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      chk("rst_busy", bus.busy, 0);
      chk("rst_opnd", bus.opnd, 0);
      ticks(20);
      chk("idle_opnd", bus.opnd, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_vec_count", bus.vec_count, 0);
      chk("idle_signature", bus.signature, 0);

      // zero result, operand sequence and hold time
      start_run();
      chk("start_busy", bus.busy, 1);
      ticks(1);
      chk("opnd_first", bus.opnd, 60'h1);
      ticks(3);
      chk("opnd_first_held", bus.opnd, 60'h1);
      ticks(1);
      chk("opnd_second", bus.opnd, 60'h2);
      wait_done();
      chk("zero_latency", cyc_now - s_edge, 16);
      chk("zero_vec_count", bus.vec_count, 4);
      chk("zero_signature", bus.signature, 0);
      chk("zero_busy_low", bus.busy, 0);

      // constant result y_in = 1
      y_const = 90'h1;
      start_run();
      chk("restart_done_clr", bus.done, 0);
      ticks(4);
      chk("const_sig_v1", bus.signature, 32'h1);
      chk("const_vc_v1", bus.vec_count, 1);
      ticks(4);
      chk("const_sig_v2", bus.signature, 32'h3);
      wait_done();
      chk("const_sig_final", bus.signature, 32'hF);
      chk("const_latency", cyc_now - s_edge, 16);

      // operand-dependent result, start pulsed mid-run
      y_mode  = 1'b1;
      y_const = 90'h2_1234_5678_9ABC_DEF0_1357_9B;
      start_run();
      ticks(5);
      bus.start = 1'b1;
      ticks(1);
      bus.start = 1'b0;
      wait_done();
      chk("busy_start_latency", cyc_now - s_edge, 16);
      chk("busy_start_done", bus.done, 1);

      // abort during vector 3 (settle phase)
      y_mode  = 1'b0;
      y_const = 90'h1;
      start_run();
      ticks(10);
      bus.abort = 1'b1;
      ticks(1);
      bus.abort = 1'b0;
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_vec_count", bus.vec_count, 2);
      chk("abort_signature", bus.signature, 32'h3);
      ticks(3);
      chk("abort_stays_idle", bus.busy, 0);

      // restart from SEED, then abort in the final capture
      start_run();
      chk("restart_vc_clr", bus.vec_count, 0);
      chk("restart_sig_clr", bus.signature, 0);
      ticks(1);
      chk("restart_opnd_seed", bus.opnd, 60'h1);
      ticks(14);
      bus.abort = 1'b1;
      ticks(1);
      bus.abort = 1'b0;
      chk("abort_cap_done", bus.done, 0);
      chk("abort_cap_vc", bus.vec_count, 3);
      chk("abort_cap_sig", bus.signature, 32'h7);

      // start with abort in IDLE
      bus.start = 1'b1;
      bus.abort = 1'b1;
      ticks(1);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("start_abort_busy", bus.busy, 0);
      ticks(3);
      chk("start_abort_vc", bus.vec_count, 3);

      // reset mid-run while start is held
      start_run();
      ticks(9);
      rst_n     = 1'b0;
      bus.start = 1'b1;
      ticks(1);
      chk("midrst_opnd", bus.opnd, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_sig", bus.signature, 0);
      chk("midrst_vc", bus.vec_count, 0);
      chk("midrst_done", bus.done, 0);
      rst_n     = 1'b1;
      bus.start = 1'b0;
      ticks(2);
      chk("post_rst_idle", bus.busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
